param_universal_shift_reg: RTL and testbench

- Parametrised, clocked successor to the combinational 4-bit universal shift register.
- Holds a WIDTH-bit register. Accepts commands over a valid/ready handshake: hold, parallel load, clear, and multi-cycle shift/rotate operations.
- A shift runs for a programmable number of single-bit steps, one step per clock.
- Serial inputs and outputs on both ends allow several instances to be chained into longer shift chains.

---
 rtl/param_universal_shift_reg.sv | 120 ++++++++++++
 tb/tb_param_universal_shift_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : param_universal_shift_reg
// Description : WIDTH-bit universal shift register with a valid/ready command
//               interface. Single-cycle hold/load/clear, and multi-cycle
//               shift/rotate commands that step one bit per clock for a
//               programmable count. Serial ports on both ends for chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module param_universal_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_MODE_NOP   = 3'b000;
    localparam logic [2:0] c_MODE_SHL   = 3'b001;
    localparam logic [2:0] c_MODE_SHR   = 3'b010;
    localparam logic [2:0] c_MODE_LOAD  = 3'b011;
    localparam logic [2:0] c_MODE_ROL   = 3'b100;
    localparam logic [2:0] c_MODE_ROR   = 3'b101;
    localparam logic [2:0] c_MODE_ASR   = 3'b110;
    localparam logic [2:0] c_MODE_CLEAR = 3'b111;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_remaining;
    logic [WIDTH-1:0] r_q;
    logic             r_done;
    logic [WIDTH-1:0] w_step;

    assign in_ready  = (r_state == c_ST_IDLE) && !rst;
    assign busy      = (r_state == c_ST_RUN);
    assign done      = r_done;
    assign q         = r_q;
    assign ser_out_l = r_q[WIDTH-1];
    assign ser_out_r = r_q[0];

    // One-bit step of the latched shift/rotate operation; serial inputs are live.
    always_comb begin
        w_step = r_q;
        case (r_mode)
            c_MODE_SHL: w_step = {r_q[WIDTH-2:0], ser_in_r};
            c_MODE_SHR: w_step = {ser_in_l, r_q[WIDTH-1:1]};
            c_MODE_ROL: w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            c_MODE_ROR: w_step = {r_q[0], r_q[WIDTH-1:1]};
            c_MODE_ASR: w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default:    w_step = r_q;
        endcase
    end

    // Command acceptance, step sequencing and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_mode      <= c_MODE_NOP;
            r_remaining <= '0;
            r_q         <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        case (mode)
                            c_MODE_LOAD: begin
                                r_q    <= data_in;
                                r_done <= 1'b1;
                            end
                            c_MODE_CLEAR: begin
                                r_q    <= '0;
                                r_done <= 1'b1;
                            end
                            c_MODE_NOP: begin
                                r_done <= 1'b1;
                            end
                            default: begin
                                // A zero-length shift completes like a NOP.
                                if (count == '0) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_mode      <= mode;
                                    r_remaining <= count;
                                    r_state     <= c_ST_RUN;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    r_q         <= w_step;
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_universal_shift_reg
// Description : Self-checking bench for param_universal_shift_reg (WIDTH=8):
//               directed sequences, a command vector table, randomized
//               commands against a closed-form reference model, and a
//               two-instance chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_universal_shift_reg;

    localparam int c_W = 8;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid;
    logic [2:0] mode;
    logic [7:0] data_in;
    logic [3:0] count;
    logic       ser_r, ser_l;

    logic       a_ready, a_sol, a_sor, a_busy, a_done;
    logic [7:0] a_q;
    logic       b_ready, b_sol, b_sor, b_busy, b_done;
    logic [7:0] b_q;

    int checks = 0;
    int errors = 0;

    param_universal_shift_reg #(.WIDTH(c_W)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .mode(mode), .data_in(data_in), .count(count),
        .ser_in_r(ser_r), .ser_in_l(ser_l), .q(a_q),
        .ser_out_l(a_sol), .ser_out_r(a_sor), .busy(a_busy), .done(a_done)
    );

    param_universal_shift_reg #(.WIDTH(c_W)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .mode(mode), .data_in(data_in), .count(count),
        .ser_in_r(a_sol), .ser_in_l(ser_l), .q(b_q),
        .ser_out_l(b_sol), .ser_out_r(b_sor), .busy(b_busy), .done(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] m;
        logic [7:0] d;
        logic [3:0] c;
        logic       sr;
        logic       sl;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed-form result of a whole command, computed from the step rules.
    function automatic logic [7:0] model(input logic [2:0] m, input logic [7:0] qv,
                                         input logic [7:0] d, input int n,
                                         input logic sr, input logic sl);
        logic [7:0]        r;
        logic signed [7:0] s;
        int                k;
        r = qv;
        case (m)
            3'd3: r = d;
            3'd7: r = 8'h00;
            3'd1: r = (n >= 8) ? {8{sr}} : ((qv << n) | (sr ? (8'hFF >> (8 - n)) : 8'h00));
            3'd2: r = (n >= 8) ? {8{sl}} : ((qv >> n) | (sl ? ~(8'hFF >> n) : 8'h00));
            3'd4: begin k = n % 8; r = (qv << k) | (qv >> (8 - k)); end
            3'd5: begin k = n % 8; r = (qv >> k) | (qv << (8 - k)); end
            3'd6: begin s = qv; r = s >>> n; end
            default: r = qv;
        endcase
        return r;
    endfunction

    // Issue one command on instance A and check latency, done pulse and result.
    task automatic do_cmd(input logic [2:0] m, input logic [7:0] d, input logic [3:0] c,
                          input logic sr, input logic sl, input logic [7:0] exp_q);
        int n;
        int cyc;
        n = (m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) ? int'(c) : 0;
        mode = m; data_in = d; count = c; ser_r = sr; ser_l = sl; a_valid = 1'b1;
        chk("in_ready_idle", a_ready, 1);
        tick();
        a_valid = 1'b0;
        cyc = 0;
        while (a_busy && cyc < n + 4) begin
            chk("ready_low_busy", a_ready, 0);
            chk("done_low_busy", a_done, 0);
            cyc++;
            tick();
        end
        chk("busy_cycles", cyc, n);
        chk("done_pulse", a_done, 1);
        chk("cmd_result", a_q, exp_q);
        tick();
        chk("done_one_cycle", a_done, 0);
    endtask

    initial begin
        logic [7:0] model_q;
        logic [2:0] rm;
        logic [7:0] rd;
        logic [3:0] rc;
        logic       rsr, rsl;

        vecs[0]  = '{3'd3, 8'hA5, 4'd0,  1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{3'd1, 8'h00, 4'd0,  1'b1, 1'b0, 8'hA5};
        vecs[2]  = '{3'd3, 8'h81, 4'd0,  1'b0, 1'b0, 8'h81};
        vecs[3]  = '{3'd5, 8'h00, 4'd9,  1'b0, 1'b0, 8'hC0};
        vecs[4]  = '{3'd3, 8'h90, 4'd0,  1'b0, 1'b0, 8'h90};
        vecs[5]  = '{3'd6, 8'h00, 4'd2,  1'b0, 1'b0, 8'hE4};
        vecs[6]  = '{3'd4, 8'h00, 4'd3,  1'b0, 1'b0, 8'h27};
        vecs[7]  = '{3'd2, 8'h00, 4'd10, 1'b0, 1'b1, 8'hFF};
        vecs[8]  = '{3'd0, 8'h12, 4'd7,  1'b0, 1'b0, 8'hFF};
        vecs[9]  = '{3'd7, 8'h34, 4'd5,  1'b0, 1'b0, 8'h00};
        vecs[10] = '{3'd1, 8'h00, 4'd2,  1'b1, 1'b0, 8'h03};
        vecs[11] = '{3'd3, 8'h80, 4'd0,  1'b0, 1'b0, 8'h80};
        vecs[12] = '{3'd6, 8'h00, 4'd12, 1'b0, 1'b0, 8'hFF};

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        mode = 3'd0; data_in = 8'h00; count = 4'd0; ser_r = 1'b0; ser_l = 1'b0;

        // Reset, with a LOAD presented that must not be accepted.
        tick();
        mode = 3'd3; data_in = 8'h55; a_valid = 1'b1;
        chk("rst_ready", a_ready, 0);
        tick();
        chk("rst_q", a_q, 8'h00);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ready2", a_ready, 0);
        a_valid = 1'b0; rst = 1'b0;
        #1;
        chk("ready_after_rst", a_ready, 1);
        tick();
        chk("rst_cmd_ignored", a_q, 8'h00);
        chk("rst_cmd_no_done", a_done, 0);

        // LOAD 0xA5, then SHL x3 stepping with live serial input and an ignored command.
        do_cmd(3'd3, 8'hA5, 4'd0, 1'b0, 1'b0, 8'hA5);
        mode = 3'd1; count = 4'd3; ser_r = 1'b1; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("shl_accept_q", a_q, 8'hA5);
        chk("shl_busy", a_busy, 1);
        mode = 3'd3; data_in = 8'h00; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("shl_step1", a_q, 8'h4B);
        tick();
        chk("shl_step2", a_q, 8'h97);
        chk("shl_ready_busy", a_ready, 0);
        tick();
        chk("shl_step3", a_q, 8'h2F);
        chk("shl_done", a_done, 1);
        chk("shl_idle", a_busy, 0);
        // Back-to-back accept in the done cycle.
        mode = 3'd3; data_in = 8'h3C; a_valid = 1'b1;
        chk("b2b_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        chk("b2b_q", a_q, 8'h3C);
        chk("b2b_done", a_done, 1);
        tick();
        chk("b2b_done_clear", a_done, 0);

        // Command table.
        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].m, vecs[i].d, vecs[i].c, vecs[i].sr, vecs[i].sl, vecs[i].exp_q);
        end

        // Randomized commands against the reference model.
        model_q = a_q;
        for (int i = 0; i < 60; i++) begin
            rm  = 3'($urandom_range(0, 7));
            rd  = 8'($urandom);
            rc  = 4'($urandom_range(0, 15));
            rsr = 1'($urandom);
            rsl = 1'($urandom);
            model_q = model(rm, model_q, rd, int'(rc), rsr, rsl);
            do_cmd(rm, rd, rc, rsr, rsl, model_q);
        end

        // Reset in the middle of a SHR run.
        do_cmd(3'd3, 8'hFF, 4'd0, 1'b0, 1'b0, 8'hFF);
        mode = 3'd2; count = 4'd5; ser_l = 1'b0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        chk("mid_run_q", a_q, 8'h3F);
        rst = 1'b1;
        tick();
        chk("abort_q", a_q, 8'h00);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        rst = 1'b0;
        #1;
        chk("abort_ready", a_ready, 1);
        tick();
        chk("abort_no_done", a_done, 0);
        chk("abort_q_hold", a_q, 8'h00);

        // Chain: A.ser_out_l feeds B.ser_in_r.
        mode = 3'd3; data_in = 8'hF0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; data_in = 8'h00; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        mode = 3'd1; count = 4'd4; ser_r = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("chain_a", a_q, 8'h00);
        chk("chain_b", b_q, 8'h0F);
        chk("chain_done_a", a_done, 1);
        chk("chain_done_b", b_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
